// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NUM_RD async read ports, busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned D_WIDTH  = 32'd32,
  parameter int unsigned A_WIDTH  = 32'd5,
  parameter int unsigned NUM_RD   = 32'd4,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we0,
  input  logic [A_WIDTH-1:0]          waddr0,
  input  logic [D_WIDTH-1:0]          wdata0,
  input  logic                        we1,
  input  logic [A_WIDTH-1:0]          waddr1,
  input  logic [D_WIDTH-1:0]          wdata1,
  input  logic                        set_en,
  input  logic [A_WIDTH-1:0]          set_addr,
  input  logic [NUM_RD*A_WIDTH-1:0]   raddr,
  output logic [NUM_RD*D_WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]           rbusy
);

  localparam int unsigned DEPTH = 32'd1 << A_WIDTH;

  logic [D_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]   busy_r;
  logic [DEPTH-1:0]   busy_nxt_s;
  logic               wr0_ok_s;
  logic               wr1_ok_s;
  logic               set_ok_s;

  // Qualify writes and sets against the hardwired zero register.
  always_comb begin
    wr0_ok_s = we0    && !(ZERO_REG && (waddr0   == {A_WIDTH{1'b0}}));
    wr1_ok_s = we1    && !(ZERO_REG && (waddr1   == {A_WIDTH{1'b0}}));
    set_ok_s = set_en && !(ZERO_REG && (set_addr == {A_WIDTH{1'b0}}));
  end

  // Next busy vector: a new producer's set outranks a retiring write's clear.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < int'(DEPTH); i++) begin
      busy_nxt_s[i] = (set_ok_s && (set_addr == A_WIDTH'(i))) ? 1'b1 :
                      ((wr0_ok_s && (waddr0 == A_WIDTH'(i))) ||
                       (wr1_ok_s && (waddr1 == A_WIDTH'(i)))) ? 1'b0 : busy_r[i];
    end
  end

  // Register array and busy vector; port 1 is applied last so it wins a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {D_WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (wr0_ok_s) begin
        mem_r[waddr0] <= wdata0;
      end
      if (wr1_ok_s) begin
        mem_r[waddr1] <= wdata1;
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Combinational read ports, with optional forwarding of same-cycle writes.
  always_comb begin
    logic [A_WIDTH-1:0] ra_s;
    logic [D_WIDTH-1:0] rd_s;
    logic               rb_s;
    rdata = {(NUM_RD*D_WIDTH){1'b0}};
    rbusy = {NUM_RD{1'b0}};
    ra_s  = {A_WIDTH{1'b0}};
    rd_s  = {D_WIDTH{1'b0}};
    rb_s  = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra_s = raddr[k*A_WIDTH +: A_WIDTH];
`ifdef REGFILE_BYPASS_EN
      // A forwarded write reads as not busy unless an issue re-claims an already busy register.
      if (wr1_ok_s && (waddr1 == ra_s)) begin
        rd_s = wdata1;
        rb_s = set_ok_s && (set_addr == ra_s) && busy_r[ra_s];
      end else if (wr0_ok_s && (waddr0 == ra_s)) begin
        rd_s = wdata0;
        rb_s = set_ok_s && (set_addr == ra_s) && busy_r[ra_s];
      end else begin
        rd_s = mem_r[ra_s];
        rb_s = busy_r[ra_s];
      end
`else
      rd_s = mem_r[ra_s];
      rb_s = busy_r[ra_s];
`endif
      rdata[k*D_WIDTH +: D_WIDTH] = (ZERO_REG && (ra_s == {A_WIDTH{1'b0}})) ? {D_WIDTH{1'b0}} : rd_s;
      rbusy[k]                    = (ZERO_REG && (ra_s == {A_WIDTH{1'b0}})) ? 1'b0 : rb_s;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then randomized traffic against a reference model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           we0, we1, set_en;
  logic [AW-1:0]  waddr0, waddr1, set_addr;
  logic [DW-1:0]  wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;

  regfile_mp #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .set_en(set_en), .set_addr(set_addr),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rb;
    int               tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: register values and which registers await a producer.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  function automatic exp_t predict(input int tag);
    exp_t e;
    int a;
    logic [DW-1:0] d;
    bit b;
    e.tag = tag;
    e.rd = '0;
    e.rb = '0;
    for (int k = 0; k < NR; k++) begin
      a = int'(raddr[k*AW +: AW]);
      d = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (we1 && a != 0 && int'(waddr1) == a) begin
        d = wdata1;
        b = set_en && int'(set_addr) == a && m_busy[a];
      end else if (we0 && a != 0 && int'(waddr0) == a) begin
        d = wdata0;
        b = set_en && int'(set_addr) == a && m_busy[a];
      end
`endif
      if (a == 0) begin
        d = '0;
        b = 1'b0;
      end
      e.rd[k*DW +: DW] = d;
      e.rb[k] = b;
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we0 && waddr0 != 5'd0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 5'd0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (set_en && set_addr != 5'd0) m_busy[set_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; set_en = 1'b0;
    waddr0 = '0; waddr1 = '0; set_addr = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
    raddr = {a3, a2, a1, a0};
  endtask

  // One cycle: queue the expected read view for this cycle, then advance the model at the edge.
  task automatic step(input int tag, input bit chk);
    if (chk) sb.push_back(predict(tag));
    @(posedge clk);
    model_edge();
    #1;
    idle();
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued entry is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (rdata !== mon_e.rd) begin
        n_bad++;
        $display("FAIL rdata tag=%0d got=%h want=%h", mon_e.tag, rdata, mon_e.rd);
      end
      n_cmp++;
      if (rbusy !== mon_e.rb) begin
        n_bad++;
        $display("FAIL rbusy tag=%0d got=%b want=%b", mon_e.tag, rbusy, mon_e.rb);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    idle();
    raddr = '0;
    @(posedge clk); #1;
    // Power-up reset: DUT state is unknown until the first reset edge.
    rst = 1'b1; step(0, 1'b0);
    rst = 1'b1; step(0, 1'b0);
    for (int a = 0; a < 8; a++) begin
      set_rd(AW'(a*4), AW'(a*4+1), AW'(a*4+2), AW'(a*4+3));
      step(1, 1'b1);
    end
    // Reset clears data written before it.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_en = 1'b1; set_addr = 5'd6;
    set_rd(5'd5, 5'd6, 5'd5, 5'd6);
    step(2, 1'b1);
    step(2, 1'b1);
    rst = 1'b1; step(2, 1'b1);
    rst = 1'b1; step(2, 1'b1);
    step(2, 1'b1);
    // Same-address dual write: port 1 wins.
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11; we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h22;
    set_rd(5'd3, 5'd3, 5'd3, 5'd3);
    step(3, 1'b1);
    step(3, 1'b1);
    // Zero register ignores writes and sets.
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    set_en = 1'b1; set_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    step(4, 1'b1);
    step(4, 1'b1);
    // Busy scoreboard set / clear / set-beats-clear.
    set_rd(5'd7, 5'd7, 5'd7, 5'd7);
    set_en = 1'b1; set_addr = 5'd7; step(5, 1'b1);
    step(5, 1'b1);
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5A; step(5, 1'b1);
    step(5, 1'b1);
    set_en = 1'b1; set_addr = 5'd7; step(5, 1'b1);
    set_en = 1'b1; set_addr = 5'd7; we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h66; step(5, 1'b1);
    step(5, 1'b1);
    // Same-cycle read of a register being written.
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77; step(6, 1'b0);
    set_rd(5'd9, 5'd9, 5'd9, 5'd9);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1234; step(6, 1'b1);
    step(6, 1'b1);
    // Reset overrides a write and a set in the same cycle.
    set_rd(5'd4, 5'd4, 5'd4, 5'd4);
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h99; set_en = 1'b1; set_addr = 5'd4; rst = 1'b1;
    step(7, 1'b1);
    step(7, 1'b1);
    // Randomized traffic, addresses biased low so conflicts and forwarding hits are common.
    for (int n = 0; n < 3000; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      set_en = 1'($urandom_range(0, 1));
      waddr0 = AW'($urandom_range(0, 7));
      waddr1 = AW'($urandom_range(0, 7));
      set_addr = AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      wdata1 = $urandom;
      rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < NR; k++) begin
        raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      step(8, 1'b1);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32I core's next generation. It provides two write ports for dual writeback, `NUM_RD` asynchronous read ports, and a per-register busy scoreboard for issue-stage hazard checks. It sits between decode/issue (read and busy lookup) and writeback (register writes and busy clear).

## Interface
- `D_WIDTH`, 32, register data width in bits.
- `A_WIDTH`, 5, register address width; depth is 2^`A_WIDTH`.
- `NUM_RD`, 4, number of read ports (1..8).
- `ZERO_REG`, 1, when 1, register 0 is hardwired to zero and never busy.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we0` in 1: write enable, port 0.
- `waddr0` in `A_WIDTH`: write address, port 0.
- `wdata0` in `D_WIDTH`: write data, port 0.
- `we1` in 1: write enable, port 1.
- `waddr1` in `A_WIDTH`: write address, port 1.
- `wdata1` in `D_WIDTH`: write data, port 1.
- `set_en` in 1: mark a register busy (instruction issued with this destination).
- `set_addr` in `A_WIDTH`: register to mark busy.
- `raddr` in `NUM_RD*A_WIDTH`: packed read addresses; port k is bits [k*A_WIDTH +: A_WIDTH].
- `rdata` out `NUM_RD*D_WIDTH`: packed read data, same packing as `raddr`.
- `rbusy` out `NUM_RD`: busy flag of the register addressed by each read port.

## Operation
- **Storage:** 2^`A_WIDTH` registers of `D_WIDTH` bits, plus a 2^`A_WIDTH`-bit busy vector.
- **Reset:** `rst`=1 at a rising edge clears every register and every busy bit. Reset overrides any write or set in the same cycle.
  - Immediately after reset, all `rdata`=0 and all `rbusy`=0.
- **Write:** `weN`=1 stores `wdataN` into `waddrN` at the edge.
- **Write conflict:** if both ports write the same address in the same cycle, port 1's data is stored.
- **Zero register** (`ZERO_REG`=1):
  - Writes to address 0 are discarded.
  - `set_en` with `set_addr`=0 is discarded.
  - A read of address 0 returns 0 with `rbusy`=0, including under bypass.
- **Busy clear:** any accepted write (either port) clears the busy bit of its address.
- **Busy set:** `set_en` sets `busy[set_addr]`.
  - If the set and a clear hit the same address in the same cycle, set wins: the new producer supersedes the retiring one.
- **Read:** each port is purely combinational from the array and busy vector, subject to bypass (see Configuration).
- **Read-port independence:** any number of read ports may address the same register.

## Timing
- Read latency is 0 cycles (combinational from `raddr`).
- Write-to-read latency is 1 cycle without bypass and 0 cycles with bypass.
- `set_en` is visible on `rbusy` starting the cycle after the edge. Bypass never forwards a set.
- A write in cycle T clears busy from cycle T+1 without bypass, or from cycle T with bypass.
- There is no handshake: every write and set presented at an edge is accepted.
- Address wrap does not occur; every `A_WIDTH` value is a valid register.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** when a read port's address matches an active same-cycle write (`we0`/`we1`, non-zero when `ZERO_REG`=1):
  - `rdata` returns the write data; port 1 has priority if both ports match.
  - `rbusy` for that port is 0, unless `set_en` targets the same address and that bit is already busy.
  - This is a combinational path from `wdata`/`waddr`/`we` to `rdata`.
- **Undefined:** reads return stored array contents only, and `rbusy` reflects the stored busy vector. No combinational path from the write ports.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles after writing 0xDEADBEEF to x5 → `rdata` for x5 is 0 and all `rbusy` bits are 0.
- **Dual write, conflict:** `we0` x3=0x11 and `we1` x3=0x22 in the same cycle; next cycle read x3 on all 4 ports → every port returns 0x22.
- **Zero register:** write 0xFFFFFFFF to x0 and `set_en` x0 → reading x0 returns 0 and `rbusy`=0, with and without the macro.
- **Scoreboard:**
  - Step 1: `set_en` x7 → next cycle `rbusy`=1 for x7.
  - Step 2: `we1` x7=0x5A → after that edge, `rbusy`=0 and `rdata`=0x5A.
  - Step 3: in the same cycle, `set_en` x7 and `we0` x7 → x7 stays busy.
- **Bypass:** with `REGFILE_BYPASS_EN`, read x9 while `we0` writes x9=0x1234 → `rdata`=0x1234 in the same cycle. Without the macro → old value in that cycle, 0x1234 the next.
- **Reset mid-operation:** assert `rst` in the same cycle as `we0` x4=0x99 and `set_en` x4 → x4 reads 0 with `rbusy`=0.
